traffic_display_monitor: RTL and testbench
==========================================

Name: traffic_display_monitor

Overview:
- Receive-side checker for the traffic controller's output interface.
- Consumes the six lamp outputs and the eight 7-segment digit buses.
- Decodes the digits back to BCD and two-digit values, and reconstructs the signal phase.
- Checks the phase order and 16-cycle dwell, and reports sticky error flags plus a saturating error count.
- Sits beside the controller in the top-level and bench as an on-chip protocol monitor.

Parameters:
DWELL, 16, required number of cycles per phase
CNT_W, 8, width of err_count

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
GSN1, GSN2, GWE1, GWE2, RNS, RWE  in  1 each  lamp outputs from the controller
SN1D1, SN1D2, SN2D1, SN2D2, WE1D1, WE1D2, WE2D1, WE2D2  in  7 each  segment buses; D1 = tens, D2 = units; bit0 = seg a ... bit6 = seg g; active-high
err_clr  in  1  clears all sticky errors and err_count
phase  out  2  decoded phase, 0..3
phase_valid  out  1  lamp pattern is legal
dwell  out  5  cycles spent in the current phase, saturates at 31
val_sn1, val_sn2, val_we1, val_we2  out  7 each  decoded value = tens*10 + units; 127 if either digit is invalid
seg_err  out  8  sticky invalid-pattern flag per bus; order SN1D1..WE2D2 = bits 0..7
light_err, seq_err, timing_err  out  1 each  sticky error flags
err_count  out  CNT_W  saturating count of error cycles

Behaviour:
- Latency: every output is registered and reflects the inputs sampled at the previous rising edge (1 cycle).
- Reset value of every output is 0. The monitor FSM resets to IDLE.
- Segment codes:
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h47, 8=7'h7F, 9=7'h6F.
  - 7'h47 is the mandated code for 7, with seg g lit.
  - Any other pattern decodes to 4'hF and sets the matching seg_err bit.
- Lamp patterns: the vector {GSN1, GSN2, GWE1, GWE2, RNS, RWE} is decoded as follows.
  - P0 = 100001, P1 = 010001, P2 = 001010, P3 = 000110.
  - Anything else is illegal: phase_valid=0, light_err=1, phase holds its last value.
- Monitor FSM:
  - IDLE: no legal pattern seen yet. A legal pattern moves it to ALIGN, with dwell=1.
  - ALIGN: the first phase may have started before observation, so dwell counts but is not checked. Same phase: dwell++. On a change to phase+1 (mod 4): go to TRACK, dwell=1. On a change to any other phase: seq_err, stay in ALIGN, dwell=1.
  - TRACK, same phase: dwell++. If dwell would reach DWELL+1, raise timing_err (once per overstay) and keep counting to saturation.
  - TRACK, change to phase+1: if dwell != DWELL, raise timing_err; dwell=1.
  - TRACK, change to any other phase: seq_err, go to ALIGN, dwell=1.
  - Any state, illegal pattern: go to IDLE, dwell=0.
- Expected stream after a controller reset: P0 for 16 cycles, then P1, P2, P3, P0, and so on.
- Error accounting:
  - err_count increments by 1 on any cycle with at least one new error event, saturating at 2^CNT_W-1.
  - err_clr clears all sticky flags and err_count.
  - If err_clr and a new error occur in the same cycle, the new error wins: its flag is set and err_count=1.
- Values: computed with a constant multiply-by-10 on 4-bit digits; the result fits in 7 bits.
- RESET mid-operation: all state and outputs return to reset values at that edge. Inputs are ignored during that cycle.

Decomposition:
- Package traffic_mon_pkg holds:
  - the 10 segment code constants and SEG_INVALID;
  - the phase encodings P0..P3;
  - the four legal lamp-vector constants;
  - the FSM state enum IDLE/ALIGN/TRACK.
- Sub-module seg7_to_bcd (combinational, 7-bit in -> 4-bit digit + invalid flag), instantiated 8 times.

Test Plan:
- Legal sequence: RESET, then drive P0..P3 with 16 cycles each for 3 rounds -> phase tracks with 1-cycle lag, dwell counts 1..16, all errors stay 0, err_count=0.
- Digit decode:
  - SN1D1=7'h4F, SN1D2=7'h6D -> val_sn1=35 the next cycle.
  - WE1D1=7'h7F, WE1D2=7'h47 -> val_we1=87.
  - WE2D2=7'h00 -> seg_err[7]=1, val_we2=127, err_count=1, and seg_err[7] stays set after a valid code returns.
- Timing errors in TRACK:
  - Hold P1 for 17 cycles -> timing_err rises on the cycle dwell would reach 17.
  - Leave P2 after 15 cycles -> timing_err at the transition.
- Sequence error: after alignment, jump P0 -> P2 -> seq_err=1, FSM in ALIGN, and no timing_err at the next correct transition.
- Illegal lamps: GSN1=GWE1=1 -> light_err=1, phase_valid=0, dwell=0. Assert err_clr together with a new seg error -> light_err clears, seg_err bit sets, err_count=1.
- Saturation and reset: force 300 consecutive error cycles -> err_count=255. RESET mid-phase -> every output is 0 at the next edge.

Source files
------------

// File: rtl/traffic_mon_pkg.sv
// Shared definitions for the traffic display monitor.
//   - 7-segment codes for digits 0..9 (bit0 = seg a ... bit6 = seg g, active-high)
//   - SEG_INVALID digit returned for any unrecognised segment pattern
//   - phase encodings and the four legal lamp vectors {GSN1,GSN2,GWE1,GWE2,RNS,RWE}
//   - monitor FSM state enum and a lamp-vector decoder
package traffic_mon_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    // The controller lights seg g for 7, so 7'h07 is deliberately not accepted.
    localparam logic [6:0] SEG_7 = 7'h47;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic [3:0] SEG_INVALID = 4'hF;

    localparam logic [1:0] PH_P0 = 2'd0;
    localparam logic [1:0] PH_P1 = 2'd1;
    localparam logic [1:0] PH_P2 = 2'd2;
    localparam logic [1:0] PH_P3 = 2'd3;

    localparam logic [5:0] LAMP_P0 = 6'b100001;
    localparam logic [5:0] LAMP_P1 = 6'b010001;
    localparam logic [5:0] LAMP_P2 = 6'b001010;
    localparam logic [5:0] LAMP_P3 = 6'b000110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        TRACK = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] phase;
    } lamp_dec_t;

    function automatic lamp_dec_t decode_lamps(input logic [5:0] v);
        lamp_dec_t r;
        r.legal = 1'b1;
        r.phase = PH_P0;
        case (v)
            LAMP_P0: r.phase = PH_P0;
            LAMP_P1: r.phase = PH_P1;
            LAMP_P2: r.phase = PH_P2;
            LAMP_P3: r.phase = PH_P3;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/traffic_display_monitor_if.sv
// Controller output bundle observed by the monitor.
//   Lamps : GSN1, GSN2, GWE1, GWE2, RNS, RWE (1 bit each)
//   Digits: SN1D1..WE2D2 (7 bits each), D1 = tens, D2 = units
//   master: the side that drives the display (controller or bench)
//   slave : the monitor, which only observes
interface traffic_display_monitor_if;
    logic       GSN1, GSN2, GWE1, GWE2, RNS, RWE;
    logic [6:0] SN1D1, SN1D2, SN2D1, SN2D2;
    logic [6:0] WE1D1, WE1D2, WE2D1, WE2D2;

    modport master (
        output GSN1, GSN2, GWE1, GWE2, RNS, RWE,
        output SN1D1, SN1D2, SN2D1, SN2D2, WE1D1, WE1D2, WE2D1, WE2D2
    );

    modport slave (
        input GSN1, GSN2, GWE1, GWE2, RNS, RWE,
        input SN1D1, SN1D2, SN2D1, SN2D2, WE1D1, WE1D2, WE2D1, WE2D2
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment to BCD decoder.
//   seg     in  7  segment pattern, bit0 = seg a ... bit6 = seg g
//   digit   out 4  decoded digit 0..9, SEG_INVALID otherwise
//   invalid out 1  pattern is not one of the ten digit codes
module seg7_to_bcd
    import traffic_mon_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       invalid
);

    always_comb begin
        invalid = 1'b0;
        digit   = SEG_INVALID;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/traffic_display_monitor.sv
// Receive-side protocol monitor for the traffic controller display.
//   CLK, RESET    clock and synchronous active-high reset
//   disp          lamp and digit bundle (slave modport)
//   err_clr       clears sticky error flags and err_count
//   phase         last legal phase seen, phase_valid = current lamps legal
//   dwell         cycles in the current phase, saturating at 31
//   val_*         two-digit value per display, 127 when a digit is invalid
//   seg_err       sticky invalid-pattern flag per bus (SN1D1..WE2D2 = bits 0..7)
//   light_err, seq_err, timing_err  sticky error flags
//   err_count     saturating count of cycles carrying a new error
// All outputs are registered: one cycle after the inputs they describe.
module traffic_display_monitor
    import traffic_mon_pkg::*;
#(
    parameter int DWELL = 16,
    parameter int CNT_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    traffic_display_monitor_if.slave disp,
    input  logic                     err_clr,
    output logic [1:0]               phase,
    output logic                     phase_valid,
    output logic [4:0]               dwell,
    output logic [6:0]               val_sn1,
    output logic [6:0]               val_sn2,
    output logic [6:0]               val_we1,
    output logic [6:0]               val_we2,
    output logic [7:0]               seg_err,
    output logic                     light_err,
    output logic                     seq_err,
    output logic                     timing_err,
    output logic [CNT_W-1:0]         err_count
);

    localparam logic [4:0]       DWELL_V   = 5'(DWELL);
    localparam logic [4:0]       DWELL_MAX = 5'd31;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    function automatic logic [6:0] pair_value(input logic [3:0] tens,
                                              input logic [3:0] units,
                                              input logic       bad);
        if (bad) return 7'd127;
        return ({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

    function automatic logic [4:0] sat_inc_dwell(input logic [4:0] d);
        return (d == DWELL_MAX) ? d : d + 5'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    mon_state_t state_p1;
    lamp_dec_t  lamp;
    logic [6:0] seg_bus [8];
    logic [3:0] digit   [8];
    logic [7:0] seg_inv;
    logic       same_ph, next_ph;
    logic       ev_light, ev_seq, ev_timing, any_ev;

    // Stage 0: combinational decode of the sampled display inputs
    assign lamp = decode_lamps({disp.GSN1, disp.GSN2, disp.GWE1, disp.GWE2, disp.RNS, disp.RWE});

    assign seg_bus[0] = disp.SN1D1;
    assign seg_bus[1] = disp.SN1D2;
    assign seg_bus[2] = disp.SN2D1;
    assign seg_bus[3] = disp.SN2D2;
    assign seg_bus[4] = disp.WE1D1;
    assign seg_bus[5] = disp.WE1D2;
    assign seg_bus[6] = disp.WE2D1;
    assign seg_bus[7] = disp.WE2D2;

    for (genvar i = 0; i < 8; i++) begin : g_dec
        seg7_to_bcd u_dec (
            .seg     (seg_bus[i]),
            .digit   (digit[i]),
            .invalid (seg_inv[i])
        );
    end

    // Phase comparisons are against the registered phase, i.e. the last legal one.
    assign same_ph = (lamp.phase == phase);
    assign next_ph = (lamp.phase == phase + 2'd1);

    assign ev_light  = ~lamp.legal;
    assign ev_seq    = lamp.legal && (state_p1 != IDLE) && !same_ph && !next_ph;
    // Overstay fires only on the step from DWELL to DWELL+1, so once per overstay.
    assign ev_timing = lamp.legal && (state_p1 == TRACK) &&
                       ((same_ph && dwell == DWELL_V) || (next_ph && dwell != DWELL_V));
    assign any_ev    = (|seg_inv) | ev_light | ev_seq | ev_timing;

    // Stage 1: registered outputs and monitor FSM
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_p1    <= IDLE;
            phase       <= 2'd0;
            phase_valid <= 1'b0;
            dwell       <= 5'd0;
            val_sn1     <= 7'd0;
            val_sn2     <= 7'd0;
            val_we1     <= 7'd0;
            val_we2     <= 7'd0;
            seg_err     <= 8'd0;
            light_err   <= 1'b0;
            seq_err     <= 1'b0;
            timing_err  <= 1'b0;
            err_count   <= '0;
        end else begin
            phase_valid <= lamp.legal;
            if (lamp.legal) phase <= lamp.phase;

            val_sn1 <= pair_value(digit[0], digit[1], seg_inv[0] | seg_inv[1]);
            val_sn2 <= pair_value(digit[2], digit[3], seg_inv[2] | seg_inv[3]);
            val_we1 <= pair_value(digit[4], digit[5], seg_inv[4] | seg_inv[5]);
            val_we2 <= pair_value(digit[6], digit[7], seg_inv[6] | seg_inv[7]);

            // A new error in the clearing cycle survives the clear.
            seg_err    <= (seg_err & ~{8{err_clr}}) | seg_inv;
            light_err  <= (light_err & ~err_clr) | ev_light;
            seq_err    <= (seq_err & ~err_clr) | ev_seq;
            timing_err <= (timing_err & ~err_clr) | ev_timing;

            if (any_ev)
                err_count <= err_clr ? CNT_W'(1) : sat_inc_cnt(err_count);
            else if (err_clr)
                err_count <= '0;

            if (!lamp.legal) begin
                state_p1 <= IDLE;
                dwell    <= 5'd0;
            end else begin
                case (state_p1)
                    IDLE: begin
                        state_p1 <= ALIGN;
                        dwell    <= 5'd1;
                    end
                    ALIGN: begin
                        if (same_ph) begin
                            dwell <= sat_inc_dwell(dwell);
                        end else begin
                            if (next_ph) state_p1 <= TRACK;
                            dwell <= 5'd1;
                        end
                    end
                    TRACK: begin
                        if (same_ph) begin
                            dwell <= sat_inc_dwell(dwell);
                        end else begin
                            if (!next_ph) state_p1 <= ALIGN;
                            dwell <= 5'd1;
                        end
                    end
                    default: begin
                        state_p1 <= IDLE;
                        dwell    <= 5'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_display_monitor.sv
// Self-checking bench for traffic_display_monitor: a behavioural model pushes the
// expected output vector for every driven cycle; observed vectors are queued one
// cycle later and each scenario drains and compares both queues.
module tb_traffic_display_monitor;

    localparam logic [5:0] L0   = 6'b100001;
    localparam logic [5:0] L1   = 6'b010001;
    localparam logic [5:0] L2   = 6'b001010;
    localparam logic [5:0] L3   = 6'b000110;
    localparam logic [5:0] LBAD = 6'b101001;

    typedef logic [54:0] obs_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       err_clr;
    logic [5:0] lamps;
    logic [6:0] segs [8];

    logic [1:0] phase;
    logic       phase_valid;
    logic [4:0] dwell;
    logic [6:0] val_sn1, val_sn2, val_we1, val_we2;
    logic [7:0] seg_err;
    logic       light_err, seq_err, timing_err;
    logic [7:0] err_count;

    always #5 CLK = ~CLK;

    traffic_display_monitor_if disp ();

    assign disp.GSN1  = lamps[5];
    assign disp.GSN2  = lamps[4];
    assign disp.GWE1  = lamps[3];
    assign disp.GWE2  = lamps[2];
    assign disp.RNS   = lamps[1];
    assign disp.RWE   = lamps[0];
    assign disp.SN1D1 = segs[0];
    assign disp.SN1D2 = segs[1];
    assign disp.SN2D1 = segs[2];
    assign disp.SN2D2 = segs[3];
    assign disp.WE1D1 = segs[4];
    assign disp.WE1D2 = segs[5];
    assign disp.WE2D1 = segs[6];
    assign disp.WE2D2 = segs[7];

    traffic_display_monitor #(.DWELL(16), .CNT_W(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .disp        (disp),
        .err_clr     (err_clr),
        .phase       (phase),
        .phase_valid (phase_valid),
        .dwell       (dwell),
        .val_sn1     (val_sn1),
        .val_sn2     (val_sn2),
        .val_we1     (val_we1),
        .val_we2     (val_we2),
        .seg_err     (seg_err),
        .light_err   (light_err),
        .seq_err     (seq_err),
        .timing_err  (timing_err),
        .err_count   (err_count)
    );

    obs_t outs;
    assign outs = {phase, phase_valid, dwell, val_sn1, val_sn2, val_we1, val_we2,
                   seg_err, light_err, seq_err, timing_err, err_count};

    obs_t sb[$];
    obs_t got_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int         m_phase, m_state, m_dwell, m_cnt;
    logic       m_pv, m_light, m_seq, m_timing;
    logic [7:0] m_seg;
    logic [6:0] m_vals [4];
    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h47, 7'h7F, 7'h6F};

    function automatic int seg_digit(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    task automatic cycle();
        int         ph;
        bit         legal, ev_l, ev_s, ev_t;
        logic [7:0] ev_seg;
        int         d [8];
        obs_t       e;
        if (RESET) begin
            m_phase = 0; m_pv = 0; m_dwell = 0; m_state = 0; m_cnt = 0;
            m_seg = 0; m_light = 0; m_seq = 0; m_timing = 0;
            for (int i = 0; i < 4; i++) m_vals[i] = 0;
        end else begin
            legal = 1; ph = 0;
            case (lamps)
                L0: ph = 0;
                L1: ph = 1;
                L2: ph = 2;
                L3: ph = 3;
                default: legal = 0;
            endcase
            for (int i = 0; i < 8; i++) begin
                d[i] = seg_digit(segs[i]);
                ev_seg[i] = (d[i] < 0);
            end
            for (int i = 0; i < 4; i++)
                m_vals[i] = (d[2*i] < 0 || d[2*i+1] < 0) ? 7'd127 : 7'(d[2*i] * 10 + d[2*i+1]);
            ev_l = !legal; ev_s = 0; ev_t = 0;
            if (!legal) begin
                m_state = 0; m_dwell = 0;
            end else if (m_state == 0) begin
                m_state = 1; m_dwell = 1;
            end else if (ph == m_phase) begin
                if (m_state == 2 && m_dwell == 16) ev_t = 1;
                if (m_dwell < 31) m_dwell++;
            end else if (ph == (m_phase + 1) % 4) begin
                if (m_state == 2 && m_dwell != 16) ev_t = 1;
                m_state = 2; m_dwell = 1;
            end else begin
                ev_s = 1; m_state = 1; m_dwell = 1;
            end
            if (legal) m_phase = ph;
            m_pv = legal;
            if (err_clr) begin
                m_seg = 0; m_light = 0; m_seq = 0; m_timing = 0;
            end
            m_seg |= ev_seg; m_light |= ev_l; m_seq |= ev_s; m_timing |= ev_t;
            if (ev_seg != 0 || ev_l || ev_s || ev_t)
                m_cnt = err_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            else if (err_clr)
                m_cnt = 0;
        end
        e = {2'(m_phase), m_pv, 5'(m_dwell), m_vals[0], m_vals[1], m_vals[2], m_vals[3],
             m_seg, m_light, m_seq, m_timing, 8'(m_cnt)};
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got_q.push_back(outs);
    endtask

    task automatic run(input logic [5:0] l, input int n);
        lamps = l;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_cycle();
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        obs_t exp, got;
        lamps = L0; err_clr = 1'b0;
        for (int i = 0; i < 8; i++) segs[i] = 7'h3F;
        reset_cycle();
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", outs);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front(); got = got_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_sb got %h want %h", got, exp); end
        end
    endtask

    task automatic test_legal_sequence();
        logic [5:0] tab [4] = '{L0, L1, L2, L3};
        obs_t exp, got;
        reset_cycle();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 4; p++)
                for (int k = 0; k < 16; k++) begin
                    lamps = tab[p];
                    cycle();
                    checks++;
                    if (phase !== 2'(p) || dwell !== 5'(k + 1)) begin
                        errors++;
                        $display("FAIL legal_phase_dwell r%0d p%0d k%0d got %0d/%0d want %0d/%0d",
                                 r, p, k, phase, dwell, p, k + 1);
                    end
                end
        checks++;
        if ({seg_err, light_err, seq_err, timing_err, err_count} !== '0) begin
            errors++; $display("FAIL legal_no_errors got %h want 0", {seg_err, light_err, seq_err, timing_err, err_count});
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front(); got = got_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL legal_sb got %h want %h", got, exp); end
        end
    endtask

    task automatic test_digit_decode();
        obs_t exp, got;
        reset_cycle();
        segs[0] = 7'h4F; segs[1] = 7'h6D; segs[4] = 7'h7F; segs[5] = 7'h47;
        run(L0, 1);
        checks++;
        if (val_sn1 !== 7'd35 || val_we1 !== 7'd87 || err_count !== 8'd0) begin
            errors++; $display("FAIL digit_values got %0d %0d cnt %0d want 35 87 cnt 0", val_sn1, val_we1, err_count);
        end
        segs[7] = 7'h00;
        run(L0, 1);
        checks++;
        if (seg_err[7] !== 1'b1 || val_we2 !== 7'd127 || err_count !== 8'd1) begin
            errors++; $display("FAIL digit_invalid got %b %0d %0d want 1 127 1", seg_err[7], val_we2, err_count);
        end
        segs[7] = 7'h3F;
        run(L0, 1);
        checks++;
        if (seg_err !== 8'h80 || err_count !== 8'd1 || val_we2 !== 7'd0) begin
            errors++; $display("FAIL digit_sticky got %h %0d %0d want 80 1 0", seg_err, err_count, val_we2);
        end
        for (int i = 0; i < 8; i++) segs[i] = 7'h3F;
        while (sb.size() > 0) begin
            exp = sb.pop_front(); got = got_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL digit_sb got %h want %h", got, exp); end
        end
    endtask

    task automatic test_timing();
        obs_t exp, got;
        reset_cycle();
        run(L0, 5);
        run(L1, 16);
        checks++;
        if (timing_err !== 1'b0 || dwell !== 5'd16) begin
            errors++; $display("FAIL timing_p1_16 got %b %0d want 0 16", timing_err, dwell);
        end
        run(L1, 1);
        checks++;
        if (timing_err !== 1'b1 || dwell !== 5'd17 || err_count !== 8'd1) begin
            errors++; $display("FAIL timing_overstay got %b %0d %0d want 1 17 1", timing_err, dwell, err_count);
        end
        run(L2, 1);
        err_clr = 1'b1;
        run(L2, 1);
        err_clr = 1'b0;
        checks++;
        if (timing_err !== 1'b0 || err_count !== 8'd0) begin
            errors++; $display("FAIL timing_clear got %b %0d want 0 0", timing_err, err_count);
        end
        run(L2, 13);
        checks++;
        if (timing_err !== 1'b0 || dwell !== 5'd15) begin
            errors++; $display("FAIL timing_p2_15 got %b %0d want 0 15", timing_err, dwell);
        end
        run(L3, 1);
        checks++;
        if (timing_err !== 1'b1 || err_count !== 8'd1 || dwell !== 5'd1) begin
            errors++; $display("FAIL timing_early got %b %0d %0d want 1 1 1", timing_err, err_count, dwell);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front(); got = got_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL timing_sb got %h want %h", got, exp); end
        end
    endtask

    task automatic test_sequence();
        obs_t exp, got;
        reset_cycle();
        run(L3, 3);
        run(L0, 16);
        run(L2, 1);
        checks++;
        if (seq_err !== 1'b1 || timing_err !== 1'b0 || dwell !== 5'd1 || phase !== 2'd2) begin
            errors++; $display("FAIL seq_jump got %b %b %0d %0d want 1 0 1 2", seq_err, timing_err, dwell, phase);
        end
        run(L2, 4);
        run(L3, 1);
        checks++;
        if (timing_err !== 1'b0 || err_count !== 8'd1) begin
            errors++; $display("FAIL seq_realign got %b %0d want 0 1", timing_err, err_count);
        end
        run(L3, 15);
        run(L0, 1);
        checks++;
        if (timing_err !== 1'b0 || seq_err !== 1'b1 || err_count !== 8'd1) begin
            errors++; $display("FAIL seq_track got %b %b %0d want 0 1 1", timing_err, seq_err, err_count);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front(); got = got_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL seq_sb got %h want %h", got, exp); end
        end
    endtask

    task automatic test_illegal();
        obs_t exp, got;
        reset_cycle();
        run(L0, 1);
        run(L1, 2);
        run(LBAD, 1);
        checks++;
        if (light_err !== 1'b1 || phase_valid !== 1'b0 || dwell !== 5'd0 || phase !== 2'd1) begin
            errors++; $display("FAIL illegal_lamps got %b %b %0d %0d want 1 0 0 1", light_err, phase_valid, dwell, phase);
        end
        err_clr = 1'b1; segs[2] = 7'h00;
        run(L1, 1);
        err_clr = 1'b0; segs[2] = 7'h3F;
        checks++;
        if (light_err !== 1'b0 || seg_err !== 8'h04 || err_count !== 8'd1 || val_sn2 !== 7'd127) begin
            errors++; $display("FAIL clear_vs_new got %b %h %0d %0d want 0 04 1 127", light_err, seg_err, err_count, val_sn2);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front(); got = got_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL illegal_sb got %h want %h", got, exp); end
        end
    endtask

    task automatic test_saturation_reset();
        obs_t exp, got;
        reset_cycle();
        run(LBAD, 300);
        checks++;
        if (err_count !== 8'd255 || light_err !== 1'b1) begin
            errors++; $display("FAIL sat_count got %0d %b want 255 1", err_count, light_err);
        end
        run(L0, 3);
        RESET = 1'b1; lamps = LBAD; segs[0] = 7'h00;
        cycle();
        RESET = 1'b0; segs[0] = 7'h3F;
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL mid_reset got %h want 0", outs);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front(); got = got_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL sat_sb got %h want %h", got, exp); end
        end
    endtask

    initial begin
        RESET = 1'b1;
        test_reset();
        test_legal_sequence();
        test_digit_decode();
        test_timing();
        test_sequence();
        test_illegal();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
